word_deserializer: RTL and testbench

WORD_DESERIALIZER -- requirements
Module: word_deserializer

---
 rtl/word_deserializer.sv | 86 ++++++++
 tb/tb_word_deserializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/word_deserializer.sv
// Serial-to-parallel word assembler with a one-word holding register.
// A completed word is dropped, and overrun set, if the holder is still occupied.
module word_deserializer #(
  parameter int N         = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 clear,
  output logic [N-1:0]         word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [$clog2(N)-1:0] bit_count,
  output logic                 overrun
);

  localparam int CW = $clog2(N);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] sr;
  logic [N-1:0] sr_nx;
  logic         accept;
  logic         done;
  logic         hs;
  logic         load;

  assign accept = sin_valid & ~clear;
  assign sr_nx  = MSB_FIRST ? {sr[N-2:0], sin}
                            : {sin, sr[N-1:1]};
  assign done   = accept && (bit_count == CW'(N-1));
  assign hs     = word_valid & word_ready;
  // holder is free if empty or being drained on this edge
  assign load   = done & ((state == EMPTY) | word_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      clear:                state_nx = EMPTY;
      done:                 state_nx = FULL;
      hs & ~done & ~clear:  state_nx = EMPTY;
      default:              state_nx = state;
    endcase
  end

  always_comb begin
    word_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      bit_count <= '0;
      word_out  <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      sr        <= '0;
      bit_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        sr        <= sr_nx;
        bit_count <= done ? '0 : bit_count + CW'(1);
      end
      if (load) begin
        word_out <= sr_nx;
      end
      if (done && (state == FULL) && !word_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: MSB-first instance is scoreboarded,
// an LSB-first twin on the same stream checks bit order.
module tb_word_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        sin_valid;
  logic        clear;
  logic        word_ready;
  logic [31:0] wm;
  logic [31:0] wl;
  logic        vm;
  logic        vl;
  logic [4:0]  cm;
  logic [4:0]  cl;
  logic        om;
  logic        ol;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  word_deserializer #(.N(32), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .clear(clear), .word_out(wm), .word_valid(vm),
    .word_ready(word_ready), .bit_count(cm), .overrun(om)
  );

  word_deserializer #(.N(32), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .clear(clear), .word_out(wl), .word_valid(vl),
    .word_ready(word_ready), .bit_count(cl), .overrun(ol)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs are stable here, so valid&ready means a handshake next edge
  always @(negedge clk) begin
    if (rst_n && vm && word_ready && !clear) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", {32'h0, wm}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("sb_word", {32'h0, wm}, {32'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push);
    if (push) sb.push_back(w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic consume();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst_n      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    clear      = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    chk("rst_word_out", {32'h0, wm}, 64'h0);
    chk("rst_valid", {63'h0, vm}, 64'h0);
    chk("rst_count", {59'h0, cm}, 64'h0);
    chk("rst_overrun", {63'h0, om}, 64'h0);
    rst_n = 1'b1;
    tick();

    // single word, MSB-first and LSB-first views
    sb.push_back(32'h8000_0001);
    d = 32'h8000_0001;
    for (int i = 31; i >= 1; i--) send_bit(d[i]);
    chk("pre_complete_valid", {63'h0, vm}, 64'h0);
    chk("count_31", {59'h0, cm}, 64'd31);
    send_bit(d[0]);
    chk("msb_valid", {63'h0, vm}, 64'h1);
    chk("msb_word", {32'h0, wm}, 64'h8000_0001);
    chk("lsb_word", {32'h0, wl}, 64'h8000_0001);
    chk("msb_overrun", {63'h0, om}, 64'h0);
    chk("count_wrap", {59'h0, cm}, 64'h0);
    consume();
    chk("drained", {63'h0, vm}, 64'h0);

    send_word(32'hF000_0000, 1'b1);
    chk("msb_f0", {32'h0, wm}, 64'hF000_0000);
    chk("lsb_reversed", {32'h0, wl}, 64'h0000_000F);
    consume();

    // overrun: second word dropped while holder is occupied
    send_word(32'h1234_5678, 1'b1);
    send_word(32'h9ABC_DEF0, 1'b0);
    chk("ovr_keep_a", {32'h0, wm}, 64'h1234_5678);
    chk("ovr_flag", {63'h0, om}, 64'h1);
    chk("ovr_count", {59'h0, cm}, 64'h0);
    chk("ovr_valid", {63'h0, vm}, 64'h1);
    consume();
    chk("ovr_sticky", {63'h0, om}, 64'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_overrun", {63'h0, om}, 64'h0);

    // handshake on the same edge as the next completion
    send_word(32'hCAFE_0001, 1'b1);
    d = 32'h0BAD_F00D;
    sb.push_back(d);
    for (int i = 31; i >= 1; i--) send_bit(d[i]);
    word_ready = 1'b1;
    send_bit(d[0]);
    chk("same_edge_word", {32'h0, wm}, 64'h0BAD_F00D);
    chk("same_edge_valid", {63'h0, vm}, 64'h1);
    send_word(32'h1111_2222, 1'b1);
    send_word(32'h3333_4444, 1'b1);
    tick();
    word_ready = 1'b0;
    chk("b2b_overrun", {63'h0, om}, 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    // partial word with gaps, then clear with competing inputs
    for (int i = 0; i < 17; i++) begin
      send_bit(i[0]);
      repeat (5) tick();
    end
    chk("gap_count", {59'h0, cm}, 64'd17);
    clear      = 1'b1;
    sin_valid  = 1'b1;
    sin        = 1'b1;
    word_ready = 1'b1;
    tick();
    clear      = 1'b0;
    sin_valid  = 1'b0;
    word_ready = 1'b0;
    chk("clear_count", {59'h0, cm}, 64'h0);
    chk("clear_valid", {63'h0, vm}, 64'h0);
    send_word(32'hA5A5_5A5A, 1'b1);
    chk("post_clear_word", {32'h0, wm}, 64'hA5A5_5A5A);
    consume();

    // asynchronous reset while full with overrun set
    send_word(32'h0F0F_0F0F, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    chk("pre_rst_overrun", {63'h0, om}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'h0, vm}, 64'h0);
    chk("arst_overrun", {63'h0, om}, 64'h0);
    chk("arst_word", {32'h0, wm}, 64'h0);
    chk("arst_count", {59'h0, cm}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(32'h7654_3210, 1'b1);
    chk("post_rst_word", {32'h0, wm}, 64'h7654_3210);
    consume();
    chk("final_drained", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
